// File: rtl/ahbl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahbl_pkg
//  Description : Shared AHB-Lite encodings, fill-master state type and the
//                word pattern helper used by the memory fill master.
//  Revision    : 1.0  initial release
// ============================================================================
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam int         HRESP_ERROR_BIT = 0;

    // Bursts must not cross a 1 KB address boundary.
    localparam int         BOUNDARY_BITS   = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_BURST = 3'd2,
        ST_LAST  = 3'd3,
        ST_ERR   = 3'd4,
        ST_FIN   = 3'd5
    } fill_state_t;

    // Word i of a command carries seed + i, wrapping at 2^32.
    function automatic logic [31:0] pattern_word(input logic [31:0] seed,
                                                 input logic [31:0] idx);
        return seed + idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahbl_mem_fill_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahbl_mem_fill_master_if
//  Description : AHB-Lite bus bundle between the fill master and its slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface ahbl_mem_fill_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [31:0]           HWDATA;
    logic [31:0]           HRDATA;
    logic                  HREADY;
    logic [1:0]            HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface
`default_nettype wire

// File: rtl/ahbl_fill_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ahbl_fill_addr_gen
//  Description : Address-phase counter for the fill master. Produces HADDR,
//                the word index of the current address phase and a flag
//                marking a 1 KB boundary; holds whenever no phase is accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module ahbl_fill_addr_gen
    import ahbl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_advance,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [CNT_WIDTH-1:0]  o_idx,
    output logic                  o_boundary
);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_idx;

    // Byte lane bits of the base are forced to zero, so they are never read.
    logic w_unused_base;
    assign w_unused_base = &{1'b0, i_base_addr[1:0]};

    // Load on command start, step one word per accepted address phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_addr <= {i_base_addr[ADDR_WIDTH-1:2], 2'b00};
            r_idx  <= '0;
        end else if (i_advance) begin
            r_addr <= r_addr + ADDR_WIDTH'(4);
            r_idx  <= r_idx + 1'b1;
        end
    end

    assign o_addr     = r_addr;
    assign o_idx      = r_idx;
    assign o_boundary = (r_addr[BOUNDARY_BITS-1:0] == '0);

endmodule
`default_nettype wire

// File: rtl/ahbl_mem_fill_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahbl_mem_fill_master
//  Description : AHB-Lite initiator that writes seed+i into a word region, or
//                reads the region back and counts words that differ from it.
//  Revision    : 1.0  initial release
// ============================================================================
module ahbl_mem_fill_master
    import ahbl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  check_mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic                  bus_error,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    ahbl_mem_fill_master_if.master bus
);

    fill_state_t           r_state;
    fill_state_t           w_state_next;
    logic [1:0]            w_htrans;

    logic                  r_write;
    logic [31:0]           r_seed;
    logic [CNT_WIDTH-1:0]  r_last_idx;

    logic                  r_dp_valid;
    logic [CNT_WIDTH-1:0]  r_dp_idx;
    logic [ADDR_WIDTH-1:0] r_dp_addr;

    logic                  r_err_pend;
    logic                  r_bus_error;
    logic [CNT_WIDTH-1:0]  r_err_count;
    logic [ADDR_WIDTH-1:0] r_first_err_addr;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [CNT_WIDTH-1:0]  w_idx;
    logic                  w_boundary;
    logic                  w_start_ok;
    logic                  w_accept;
    logic                  w_err_resp;
    logic [31:0]           w_pattern;
    logic                  w_mismatch;

    logic w_unused_resp;
    assign w_unused_resp = &{1'b0, bus.HRESP[1]};

    assign w_start_ok = start && (r_state == ST_IDLE);
    assign w_accept   = w_htrans[1] && bus.HREADY;
    assign w_err_resp = bus.HRESP[HRESP_ERROR_BIT];
    assign w_pattern  = pattern_word(r_seed, 32'(r_dp_idx));
    // Read data is only meaningful on an OKAY completion of a read data phase.
    assign w_mismatch = r_dp_valid && !r_write && bus.HREADY && !w_err_resp
                        && (bus.HRDATA != w_pattern);

    ahbl_fill_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_start_ok),
        .i_advance   (w_accept),
        .i_base_addr (base_addr),
        .o_addr      (w_addr),
        .o_idx       (w_idx),
        .o_boundary  (w_boundary)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next state and HTRANS; a pending ERROR suppresses further transfers.
    always_comb begin
        w_state_next = r_state;
        w_htrans     = HTRANS_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = (word_count != '0) ? ST_ADDR : ST_FIN;
            end
            ST_ADDR, ST_BURST: begin
                if (r_err_pend) begin
                    if (bus.HREADY) w_state_next = ST_ERR;
                end else begin
                    w_htrans = ((r_state == ST_ADDR) || w_boundary) ? HTRANS_NONSEQ : HTRANS_SEQ;
                    if (bus.HREADY) w_state_next = (w_idx == r_last_idx) ? ST_LAST : ST_BURST;
                end
            end
            ST_LAST: begin
                if (bus.HREADY) w_state_next = r_err_pend ? ST_ERR : ST_FIN;
            end
            ST_ERR:  w_state_next = ST_FIN;
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Capture the command parameters when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_seed     <= '0;
            r_last_idx <= '0;
        end else if (w_start_ok) begin
            r_write    <= !check_mode;
            r_seed     <= seed;
            r_last_idx <= word_count - 1'b1;
        end
    end

    // Data-phase tracker: follows each accepted address phase by one HREADY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_valid <= 1'b0;
            r_dp_idx   <= '0;
            r_dp_addr  <= '0;
        end else if (bus.HREADY) begin
            r_dp_valid <= w_accept;
            if (w_accept) begin
                r_dp_idx  <= w_idx;
                r_dp_addr <= w_addr;
            end
        end
    end

    // Two-cycle ERROR: flag on the first (wait) cycle, clear on the second.
    always_ff @(posedge clk) begin
        if (rst)                                        r_err_pend <= 1'b0;
        else if (r_err_pend && bus.HREADY)              r_err_pend <= 1'b0;
        else if (r_dp_valid && w_err_resp && !bus.HREADY) r_err_pend <= 1'b1;
    end

    // Status latches: cleared on start, updated by compares and ERROR aborts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_error      <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
        end else if (w_start_ok) begin
            r_bus_error      <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
        end else begin
            if (w_state_next == ST_ERR) r_bus_error <= 1'b1;
            if (w_mismatch) begin
                if (r_err_count == '0) r_first_err_addr <= r_dp_addr;
                if (r_err_count != '1) r_err_count      <= r_err_count + 1'b1;
            end
        end
    end

    assign busy           = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign done           = (r_state == ST_FIN);
    assign bus_error      = r_bus_error;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;

    assign bus.HADDR  = w_addr;
    assign bus.HTRANS = w_htrans;
    assign bus.HWRITE = r_write;
    assign bus.HSIZE  = HSIZE_WORD;
    assign bus.HBURST = HBURST_INCR;
    assign bus.HWDATA = (r_write && r_dp_valid) ? w_pattern : 32'h0;

endmodule
`default_nettype wire
